// File: rtl/virtual_input_ctrl_if.sv
// Host-side command bus and virtual pin outputs of the virtual input controller.
// The master drives a command (index, op, strobe) and the slave drives the pins.
interface virtual_input_ctrl_if #(
  parameter int N_BTN  = 4,
  parameter int N_SW   = 18,
  parameter int ADDR_W = 5
);
  logic              control;
  logic [ADDR_W-1:0] number;
  logic [1:0]        op;
  logic [N_BTN-1:0]  buttons;
  logic [N_SW-1:0]   switches;
  logic              busy;
  logic              ack;
  logic              err;

  modport master (
    output control, number, op,
    input  buttons, switches, busy, ack, err
  );

  modport slave (
    input  control, number, op,
    output buttons, switches, busy, ack, err
  );
endinterface

// File: rtl/virtual_input_ctrl.sv
// Decodes host commands (toggle/set/clear/pulse/reset-all) into virtual
// push-buttons (active-low) and slide switches, with a 2-FF strobe synchroniser.
//
// state    | meaning
// ST_IDLE  | no pulse running; commands are decoded normally
// ST_PULSE | a button is held pressed until the down-counter reaches zero
module virtual_input_ctrl #(
  parameter int N_BTN        = 4,
  parameter int N_SW         = 18,
  parameter int ADDR_W       = 5,
  parameter int PULSE_CYCLES = 5000000
) (
  input logic                 clk,
  input logic                 rst_n,
  virtual_input_ctrl_if.slave bus
);
  localparam int                CNT_W    = $clog2(PULSE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(PULSE_CYCLES - 1);
  localparam logic [ADDR_W-1:0] N_TOT    = ADDR_W'(N_BTN + N_SW);

  localparam logic [1:0] OP_TOGGLE = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_PULSE  = 2'b11;

  typedef enum logic {ST_IDLE, ST_PULSE} state_t;

  state_t            state_q, state_d;
  logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
  logic [1:0]        warm_q, warm_d;
  logic              arm_q, arm_d;
  logic [N_BTN-1:0]  btn_q, btn_d, pmask_q, pmask_d;
  logic [N_SW-1:0]   sw_q, sw_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ack_q, ack_d, err_q, err_d;
  logic [N_BTN-1:0]  btn_mask;
  logic [N_SW-1:0]   sw_mask;
  logic              is_all;
  logic              cmd_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      warm_q  <= 2'b00;
      arm_q   <= 1'b0;
      btn_q   <= '1;
      pmask_q <= '0;
      sw_q    <= '0;
      cnt_q   <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      s3_q    <= s3_d;
      warm_q  <= warm_d;
      arm_q   <= arm_d;
      btn_q   <= btn_d;
      pmask_q <= pmask_d;
      sw_q    <= sw_d;
      cnt_q   <= cnt_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    s1_d    = bus.control;
    s2_d    = s1_q;
    s3_d    = s2_q;
    warm_d  = {warm_q[0], 1'b1};
    // Commands are armed only once the synchroniser has seen control low after
    // reset, so a strobe that rose during reset never executes.
    arm_d   = arm_q | (warm_q[1] & ~s2_q);
    state_d = state_q;
    btn_d   = btn_q;
    pmask_d = pmask_q;
    sw_d    = sw_q;
    cnt_d   = cnt_q;
    ack_d   = 1'b0;
    err_d   = 1'b0;

    btn_mask = '0;
    sw_mask  = '0;
    for (int i = 0; i < N_BTN; i++)
      if (bus.number == ADDR_W'(i)) btn_mask[N_BTN-1-i] = 1'b1;
    for (int j = 0; j < N_SW; j++)
      if (bus.number == ADDR_W'(N_BTN + j)) sw_mask[N_SW-1-j] = 1'b1;
    is_all    = (bus.number >= N_TOT);
    cmd_valid = s2_q & ~s3_q & arm_q;

    if (state_q == ST_PULSE) begin
      if (cnt_q == '0) begin
        state_d = ST_IDLE;
        btn_d   = btn_q | pmask_q;
        pmask_d = '0;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    // A command landing on the release edge still sees busy and is refused.
    if (cmd_valid) begin
      if (is_all) begin
        state_d = ST_IDLE;
        btn_d   = '1;
        sw_d    = '0;
        pmask_d = '0;
        cnt_d   = '0;
        ack_d   = 1'b1;
      end else if (state_q == ST_PULSE) begin
        err_d = 1'b1;
      end else if (|btn_mask) begin
        ack_d = 1'b1;
        case (bus.op)
          OP_TOGGLE: btn_d = btn_q ^ btn_mask;
          OP_SET:    btn_d = btn_q & ~btn_mask;
          OP_CLEAR:  btn_d = btn_q | btn_mask;
          default: begin
            btn_d   = btn_q & ~btn_mask;
            pmask_d = btn_mask;
            cnt_d   = CNT_LOAD;
            state_d = ST_PULSE;
          end
        endcase
      end else if (bus.op == OP_PULSE) begin
        err_d = 1'b1;
      end else begin
        ack_d = 1'b1;
        case (bus.op)
          OP_TOGGLE: sw_d = sw_q ^ sw_mask;
          OP_SET:    sw_d = sw_q | sw_mask;
          default:   sw_d = sw_q & ~sw_mask;
        endcase
      end
    end
  end

  assign bus.buttons  = btn_q;
  assign bus.switches = sw_q;
  assign bus.busy     = (state_q == ST_PULSE);
  assign bus.ack      = ack_q;
  assign bus.err      = err_q;
endmodule

// File: tb/tb_virtual_input_ctrl.sv
// Directed bench for virtual_input_ctrl: an event-level model predicts every
// cycle's outputs, and literal expectations pin the model at key points.
module tb_virtual_input_ctrl;
  localparam int N_BTN  = 4;
  localparam int N_SW   = 18;
  localparam int ADDR_W = 5;
  localparam int PC     = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  virtual_input_ctrl_if #(.N_BTN(N_BTN), .N_SW(N_SW), .ADDR_W(ADDR_W)) vif ();

  virtual_input_ctrl #(
    .N_BTN(N_BTN), .N_SW(N_SW), .ADDR_W(ADDR_W), .PULSE_CYCLES(PC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (vif.slave)
  );

  typedef struct {int num; int op; int eff;} cmd_t;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   errors = 0;
  int   checks = 0;
  cmd_t pend[$];

  logic [N_BTN-1:0] m_btn;
  logic [N_SW-1:0]  m_sw;
  logic             m_busy, m_ack, m_err;
  int               m_rel, m_pbit;
  int               ack_cnt, err_cnt, low0_cnt, busy_cnt;
  int               a0, e0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_btn  = '1;
    m_sw   = '0;
    m_busy = 1'b0;
    m_ack  = 1'b0;
    m_err  = 1'b0;
    m_rel  = 0;
    m_pbit = 0;
  endtask

  // Effect of a command at output edge 'now', from the index map and op rules.
  task automatic model_apply(input cmd_t c, input bit was_busy, input int now);
    int b, s;
    if (c.num >= N_BTN + N_SW) begin
      m_btn  = '1;
      m_sw   = '0;
      m_busy = 1'b0;
      m_ack  = 1'b1;
    end else if (was_busy) begin
      m_err = 1'b1;
    end else if (c.num < N_BTN) begin
      b = N_BTN - 1 - c.num;
      m_ack = 1'b1;
      case (c.op)
        0: m_btn[b] = ~m_btn[b];
        1: m_btn[b] = 1'b0;
        2: m_btn[b] = 1'b1;
        default: begin
          m_btn[b] = 1'b0;
          m_busy   = 1'b1;
          m_rel    = now + PC;
          m_pbit   = b;
        end
      endcase
    end else begin
      s = N_SW - 1 - (c.num - N_BTN);
      if (c.op == 3) m_err = 1'b1;
      else begin
        m_ack = 1'b1;
        case (c.op)
          0:       m_sw[s] = ~m_sw[s];
          1:       m_sw[s] = 1'b1;
          default: m_sw[s] = 1'b0;
        endcase
      end
    end
  endtask

  // Strobe raised just after edge P takes effect on edge P+3 (2-FF sync + edge detect).
  task automatic cmd(input int num, input int op);
    cmd_t c;
    @(posedge clk);
    #1;
    vif.number = ADDR_W'(num);
    vif.op     = 2'(op);
    #1 vif.control = 1'b1;
    c.num = num;
    c.op  = op;
    c.eff = cyc + 3;
    pend.push_back(c);
    @(posedge clk);
    @(posedge clk);
    #1 vif.control = 1'b0;
    @(posedge clk);
  endtask

  task automatic settle();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    vif.control = 1'b0;
    vif.number  = '0;
    vif.op      = '0;
    model_reset();
    ack_cnt = 0; err_cnt = 0; low0_cnt = 0; busy_cnt = 0;

    fork
      forever begin
        bit   was_busy;
        cmd_t c;
        @(negedge clk);
        if (!rst_n) begin
          model_reset();
          pend.delete();
        end else begin
          m_ack = 1'b0;
          m_err = 1'b0;
          was_busy = m_busy;
          if (pend.size() > 0 && pend[0].eff == cyc) begin
            c = pend.pop_front();
            model_apply(c, was_busy, cyc);
          end
          if (was_busy && m_busy && cyc == m_rel) begin
            m_btn[m_pbit] = 1'b1;
            m_busy = 1'b0;
          end
        end
        chk("buttons",  32'(vif.buttons),  32'(m_btn));
        chk("switches", 32'(vif.switches), 32'(m_sw));
        chk("busy",     32'(vif.busy),     32'(m_busy));
        chk("ack",      32'(vif.ack),      32'(m_ack));
        chk("err",      32'(vif.err),      32'(m_err));
        if (vif.ack) ack_cnt++;
        if (vif.err) err_cnt++;
        if (!vif.buttons[0]) low0_cnt++;
        if (vif.busy) busy_cnt++;
      end
    join_none

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    settle();
    chk("rst_buttons",  32'(vif.buttons),  32'h0000000F);
    chk("rst_switches", 32'(vif.switches), 32'h00000000);
    chk("rst_busy",     32'(vif.busy),     32'h0);
    chk("rst_no_ack",   32'(ack_cnt),      32'h0);

    a0 = ack_cnt;
    cmd(0, 0); settle();
    chk("tog_btn3",      32'(vif.buttons), 32'h7);
    chk("tog_btn3_acks", 32'(ack_cnt - a0), 32'h1);
    cmd(21, 0); settle();
    chk("tog_sw0", 32'(vif.switches), 32'h00001);
    cmd(0, 0); cmd(21, 0); settle();
    chk("tog_restore_btn", 32'(vif.buttons),  32'hF);
    chk("tog_restore_sw",  32'(vif.switches), 32'h0);

    a0 = ack_cnt;
    cmd(4, 1); cmd(4, 1); settle();
    chk("set_sw17",      32'(vif.switches), 32'h20000);
    chk("set_twice_acks", 32'(ack_cnt - a0), 32'h2);
    cmd(4, 2); settle();
    chk("clr_sw17", 32'(vif.switches), 32'h0);

    a0 = ack_cnt; e0 = err_cnt; low0_cnt = 0; busy_cnt = 0;
    cmd(3, 3);
    cmd(5, 0);
    settle();
    chk("pulse_low_cycles",  32'(low0_cnt), 32'd4);
    chk("pulse_busy_cycles", 32'(busy_cnt), 32'd4);
    chk("pulse_acks",        32'(ack_cnt - a0), 32'h1);
    chk("busy_reject_err",   32'(err_cnt - e0), 32'h1);
    chk("busy_reject_sw16",  32'(vif.switches), 32'h0);
    chk("pulse_released",    32'(vif.buttons),  32'hF);

    e0 = err_cnt;
    cmd(6, 3); settle();
    chk("pulse_on_switch_err", 32'(err_cnt - e0), 32'h1);
    chk("pulse_on_switch_sw",  32'(vif.switches), 32'h0);

    cmd(4, 1); cmd(10, 1); cmd(21, 1); settle();
    chk("multi_set_sw", 32'(vif.switches), 32'h20801);
    a0 = ack_cnt; e0 = err_cnt;
    cmd(2, 3);
    #1;
    chk("pulse_btn1_busy", 32'(vif.busy),    32'h1);
    chk("pulse_btn1_low",  32'(vif.buttons), 32'hD);
    cmd(31, 0); settle();
    chk("rstall_buttons", 32'(vif.buttons),  32'hF);
    chk("rstall_sw",      32'(vif.switches), 32'h0);
    chk("rstall_busy",    32'(vif.busy),     32'h0);
    chk("rstall_acks",    32'(ack_cnt - a0), 32'h2);
    chk("rstall_no_err",  32'(err_cnt - e0), 32'h0);

    cmd(3, 3);
    @(posedge clk);
    #1;
    rst_n       = 1'b0;
    vif.number  = '0;
    vif.op      = 2'b00;
    vif.control = 1'b1;
    #1;
    chk("async_rst_buttons", 32'(vif.buttons), 32'hF);
    chk("async_rst_busy",    32'(vif.busy),    32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    a0 = ack_cnt;
    repeat (6) @(posedge clk);
    #1 vif.control = 1'b0;
    chk("held_strobe_no_ack", 32'(ack_cnt - a0), 32'h0);
    chk("held_strobe_btn",    32'(vif.buttons),  32'hF);
    repeat (3) @(posedge clk);
    cmd(0, 0); settle();
    chk("post_rst_cmd_btn",  32'(vif.buttons),  32'h7);
    chk("post_rst_cmd_acks", 32'(ack_cnt - a0), 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
